// File: rtl/mod_n_pkg.sv
// Shared constants for the mod-N up/down counter family: count direction
// encodings and the default geometry used by the interface, RTL and bench.
package mod_n_pkg;

  localparam logic MODE_DOWN = 1'b0;
  localparam logic MODE_UP   = 1'b1;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 12;
  localparam int DEF_STEP_W  = 2;

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Bus bundle between a driver/monitor testbench and the mod-N counter.
// The master drives the controls; the slave is the counter itself.
interface mod_n_updown_counter_if
  import mod_n_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
);

  logic              load;
  logic [WIDTH-1:0]  datain;
  logic              mode;
  logic              en;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  dataout;
  logic              wrap;
  logic              load_err;

  modport master (
    output load, datain, mode, en, step,
    input  dataout, wrap, load_err
  );

  modport slave (
    input  load, datain, mode, en, step,
    output dataout, wrap, load_err
  );

  // Passive view: write side (controls) and read side (results) together
  modport monitor (
    input load, datain, mode, en, step,
    input dataout, wrap, load_err
  );

endinterface

// File: rtl/mod_n_next.sv
// Combinational next-count logic: steps the current count up or down modulo
// MODULUS and flags when the result wrapped around the range boundary.
module mod_n_next
  import mod_n_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS,
  parameter int STEP_W  = DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              mode,
  output logic [WIDTH-1:0]  nextCount,
  output logic              wrapNext
);

  // One extra bit so count+step and count+MODULUS never overflow
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH:0] countExt;
  logic [WIDTH:0] stepExt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] result;

  always_comb begin
    countExt = {1'b0, count};
    stepExt  = (WIDTH + 1)'(step);
    sum      = countExt + stepExt;
    result   = sum;
    wrapNext = 1'b0;
    if (mode == MODE_UP) begin
      if (sum >= MOD_EXT) begin
        result   = sum - MOD_EXT;
        wrapNext = 1'b1;
      end
    end else if (countExt >= stepExt) begin
      result = countExt - stepExt;
    end else begin
      result   = countExt + MOD_EXT - stepExt;
      wrapNext = 1'b1;
    end
    nextCount = WIDTH'(result);
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-MODULUS up/down counter with programmable step, range-checked load,
// sticky load error flag and a registered wrap pulse for cascading digits.
module mod_n_updown_counter
  import mod_n_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS,
  parameter int STEP_W  = DEF_STEP_W
) (
  input logic             clk,
  input logic             rst,
  mod_n_updown_counter_if.slave bus
);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_badModulus
    $error("mod_n_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (((2 ** STEP_W) - 1) >= MODULUS) begin : g_badStep
    $error("mod_n_updown_counter: largest step must be below MODULUS");
  end

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count;
  logic             wrapReg;
  logic             loadErr;
  logic [WIDTH-1:0] nextCount;
  logic             wrapNext;

  mod_n_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .STEP_W  (STEP_W)
  ) u_next (
    .count     (count),
    .step      (bus.step),
    .mode      (bus.mode),
    .nextCount (nextCount),
    .wrapNext  (wrapNext)
  );

  // Priority is load, then enabled count, then hold; wrap only pulses on a count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      wrapReg <= 1'b0;
      loadErr <= 1'b0;
    end else if (bus.load) begin
      wrapReg <= 1'b0;
      if ({1'b0, bus.datain} < MOD_EXT) begin
        count   <= bus.datain;
        loadErr <= 1'b0;
      end else begin
        loadErr <= 1'b1;
      end
    end else if (bus.en) begin
      count   <= nextCount;
      wrapReg <= wrapNext;
    end else begin
      wrapReg <= 1'b0;
    end
  end

  assign bus.dataout  = count;
  assign bus.wrap     = wrapReg;
  assign bus.load_err = loadErr;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed, table-driven bench for the mod-12 up/down counter with step,
// plus hand-written sequences for async reset and a full two-lap sweep.
module tb_mod_n_updown_counter;
  import mod_n_pkg::*;

  localparam int WIDTH   = DEF_WIDTH;
  localparam int MODULUS = DEF_MODULUS;
  localparam int STEP_W  = DEF_STEP_W;

  typedef struct {
    logic              load;
    logic [WIDTH-1:0]  datain;
    logic              mode;
    logic              en;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  expData;
    logic              expWrap;
    logic              expErr;
  } vectorT;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   wrapCount;
  vectorT vecs[$];

  mod_n_updown_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  mod_n_updown_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .STEP_W  (STEP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic ld, input int din, input logic md, input logic e,
                        input int st, input int expD, input logic expW, input logic expE);
    vectorT v;
    v.load    = ld;
    v.datain  = WIDTH'(din);
    v.mode    = md;
    v.en      = e;
    v.step    = STEP_W'(st);
    v.expData = WIDTH'(expD);
    v.expWrap = expW;
    v.expErr  = expE;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, then let one rising edge sample the inputs
  task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] din, input logic md,
                               input logic e, input logic [STEP_W-1:0] st);
    @(negedge clk);
    bus.load   = ld;
    bus.datain = din;
    bus.mode   = md;
    bus.en     = e;
    bus.step   = st;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expD,
                             input logic expW, input logic expE);
    compared++;
    if (bus.dataout !== expD) begin
      mismatched++;
      $display("[TB] FAIL %s dataout: actual=%0d required=%0d", name, bus.dataout, expD);
    end
    compared++;
    if (bus.wrap !== expW) begin
      mismatched++;
      $display("[TB] FAIL %s wrap: actual=%0b required=%0b", name, bus.wrap, expW);
    end
    compared++;
    if (bus.load_err !== expE) begin
      mismatched++;
      $display("[TB] FAIL %s load_err: actual=%0b required=%0b", name, bus.load_err, expE);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    wrapCount  = 0;
    rst        = 1'b0;
    bus.load   = 1'b0;
    bus.datain = '0;
    bus.mode   = MODE_UP;
    bus.en     = 1'b0;
    bus.step   = '0;

    // Directed table, starting from the reset value 0
    addVec(1, 10, 1, 0, 0, 10, 0, 0);
    addVec(0,  0, 1, 1, 1, 11, 0, 0);
    addVec(0,  0, 1, 1, 1,  0, 1, 0);
    addVec(0,  0, 1, 1, 1,  1, 0, 0);
    addVec(1,  1, 0, 0, 0,  1, 0, 0);
    addVec(0,  0, 0, 1, 3, 10, 1, 0);
    addVec(0,  0, 0, 1, 3,  7, 0, 0);
    addVec(1,  5, 0, 0, 0,  5, 0, 0);
    addVec(1, 13, 1, 1, 1,  5, 0, 1);
    addVec(0,  0, 1, 1, 2,  7, 0, 1);
    addVec(1, 15, 0, 0, 0,  7, 0, 1);
    addVec(1,  4, 0, 0, 0,  4, 0, 0);
    addVec(1,  2, 1, 1, 3,  2, 0, 0);
    addVec(0,  0, 1, 0, 3,  2, 0, 0);
    addVec(0,  0, 1, 0, 3,  2, 0, 0);
    addVec(0,  0, 0, 0, 3,  2, 0, 0);
    addVec(0,  0, 0, 0, 3,  2, 0, 0);
    addVec(0,  0, 1, 1, 0,  2, 0, 0);
    addVec(0,  0, 0, 1, 0,  2, 0, 0);
    addVec(1, 12, 0, 0, 0,  2, 0, 1);
    addVec(1, 11, 0, 0, 0, 11, 0, 0);
    addVec(0,  0, 1, 1, 3,  2, 1, 0);
    addVec(0,  0, 1, 1, 3,  5, 0, 0);
    addVec(0,  0, 0, 1, 3,  2, 0, 0);
    addVec(0,  0, 0, 1, 3, 11, 1, 0);
    addVec(0,  0, 1, 1, 1,  0, 1, 0);
    addVec(0,  0, 1, 0, 1,  0, 0, 0);
    addVec(1,  0, 0, 1, 1,  0, 0, 0);
    addVec(0,  0, 0, 1, 1, 11, 1, 0);
    addVec(0,  0, 1, 1, 1,  0, 1, 0);
    addVec(0,  0, 1, 1, 0,  0, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].load, vecs[i].datain, vecs[i].mode, vecs[i].en, vecs[i].step);
      checkOutput($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expWrap, vecs[i].expErr);
    end

    // Two full laps upward by one from zero
    applyStimulus(1'b1, 4'd0, MODE_UP, 1'b0, 2'd0);
    checkOutput("sweepStart", 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 2 * MODULUS; i++) begin
      applyStimulus(1'b0, 4'd0, MODE_UP, 1'b1, 2'd1);
      checkOutput($sformatf("sweep%0d", i), WIDTH'(i % MODULUS), (i % MODULUS) == 0, 1'b0);
      if (bus.wrap === 1'b1) wrapCount++;
      compared++;
      if (!(bus.dataout < WIDTH'(MODULUS))) begin
        mismatched++;
        $display("[TB] FAIL sweepRange%0d: actual=%0d required=<%0d", i, bus.dataout, MODULUS);
      end
    end
    compared++;
    if (wrapCount != 2) begin
      mismatched++;
      $display("[TB] FAIL sweepWraps: actual=%0d required=2", wrapCount);
    end

    // Asynchronous reset mid-count with the error flag set
    applyStimulus(1'b1, 4'd5, MODE_UP, 1'b0, 2'd0);
    applyStimulus(1'b0, 4'd0, MODE_UP, 1'b1, 2'd1);
    applyStimulus(1'b1, 4'd14, MODE_UP, 1'b0, 2'd0);
    applyStimulus(1'b0, 4'd0, MODE_UP, 1'b1, 2'd1);
    checkOutput("preReset", 4'd7, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncReset", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("resetHeld", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("afterReset", 4'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
Parametrised successor to the team's mod-12 up/down counter.
- Counts modulo MODULUS, up or down, by a programmable step.
- Supports synchronous load with range checking, count enable, and a registered wrap pulse for cascading digits.
- Sits behind the same driver/monitor style testbench interface as the existing counter family.

Parameters:
WIDTH, 4, bit width of datain/dataout.
MODULUS, 12, count range 0..MODULUS-1. Elaboration checks: 2 <= MODULUS <= 2**WIDTH.
STEP_W, 2, width of step input. Elaboration check: 2**STEP_W - 1 < MODULUS.

Ports:
clk  input  1  clock, all state changes on posedge
rst  input  1  asynchronous active-low reset
load  input  1  synchronous load request
datain  input  WIDTH  load value
mode  input  1  1 = count up, 0 = count down
en  input  1  count enable
step  input  STEP_W  increment/decrement amount; 0 = hold
dataout  output  WIDTH  current count, registered
wrap  output  1  one-cycle pulse, registered, aligned with the wrapped dataout value
load_err  output  1  sticky flag: last load attempted a value >= MODULUS

Behaviour:
- Reset (rst=0, asynchronous, any time): dataout=0, wrap=0, load_err=0. Holds while rst=0. First update is at the first posedge after rst deasserts.
- Latency: one cycle; inputs sampled at posedge, dataout/wrap/load_err valid after that edge.
- Priority: load > en > hold.
- Load with datain < MODULUS: dataout<=datain, load_err<=0, wrap<=0. Load overrides en/mode/step.
- Load with datain >= MODULUS: dataout unchanged, load_err<=1, wrap<=0.
- load_err is sticky. It clears only on reset or on a valid load.
- Count (load=0, en=1, mode=1): sum = dataout + step, computed in WIDTH+1 bits.
  - If sum >= MODULUS: dataout<=sum-MODULUS, wrap<=1.
  - Else: dataout<=sum, wrap<=0.
- Count (load=0, en=1, mode=0):
  - If dataout >= step: dataout<=dataout-step, wrap<=0.
  - Else: dataout<=dataout+MODULUS-step, wrap<=1.
- step=0 with en=1: dataout holds, wrap<=0.
- en=0 and load=0: dataout holds, wrap<=0.
- wrap is never high two consecutive cycles unless a wrap occurs on consecutive counts.
- Mode change mid-count takes effect on the next enabled edge; there are no extra states.
- dataout never leaves 0..MODULUS-1 after reset.
- Counter is a single register state. The "state machine" is the count value plus wrap/err flags; no hidden states.

Decomposition:
- Package mod_n_pkg holds:
  - mode constants MODE_DOWN=1'b0, MODE_UP=1'b1;
  - default WIDTH/MODULUS/STEP_W values, shared with interface and testbench.
- One combinational sub-module, mod_n_next, computes next_count and wrap_next from (dataout, step, mode).
  - Top level does priority and registering.
- The testbench interface extends the existing one:
  - adds en and step to the driver clocking block and write monitor;
  - adds wrap and load_err to the read monitor.

Test Plan (WIDTH=4, MODULUS=12, STEP_W=2):
1. Reset mid-count: counting up at 7, drop rst between edges -> dataout=0, wrap=0, load_err=0 immediately, without waiting for clk.
2. Up wrap: load 10, then en=1 mode=1 step=1 for 3 cycles -> dataout 11, 0, 1. wrap=1 only in the cycle dataout=0.
3. Down wrap with step: load 1, en=1 mode=0 step=3 -> dataout 10 with wrap=1, then 7 with wrap=0.
4. Illegal load: load datain=13 while dataout=5 -> dataout stays 5, load_err=1. Then load 4 -> dataout=4, load_err=0.
5. Priority/hold:
   - load=1 datain=2 with en=1 mode=1 step=3 -> dataout=2, wrap=0.
   - en=0 for 4 cycles -> dataout stays 2.
   - step=0 with en=1 -> dataout stays 2.
6. Full sweep: from 0, en=1 mode=1 step=1 for 24 cycles -> sequence 1..11,0 twice, wrap exactly twice. Check dataout < 12 every cycle.
